// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin mux arbiter:
// state encoding, requester count, select width and the rotating pick.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr (wrapping 3->0) that is requesting and
  // not masked out. The loop runs from the farthest candidate down to the
  // nearest so the nearest hit is the one left standing.
  function automatic pick_t rr_pick4(input logic [NUM_REQ-1:0] req,
                                     input logic [SEL_W-1:0]   ptr,
                                     input logic [NUM_REQ-1:0] excl);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand] && !excl[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain combinational 4-to-1 single-bit multiplexer shared by the requesters.
module mux4to1 (
  input  logic [3:0] D,
  input  logic [1:0] S,
  output logic       Y
);

  assign Y = D[S];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4-to-1 mux. Each grant is bounded to
// MAX_HOLD cycles while others wait; the mux output is registered together
// with a valid flag that follows the grant by one cycle.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y,
  output logic       y_valid
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [NUM_REQ-1:0] w_owner_mask;
  pick_t              w_pick_any;
  pick_t              w_pick_other;
  logic               w_mux_y;

  logic               r_y_p1;
  logic               r_vld_p1;

  assign w_owner_mask = 4'b0001 << r_sel;
  assign w_pick_any   = rr_pick4(req, r_ptr, 4'b0000);
  assign w_pick_other = rr_pick4(req, r_ptr, w_owner_mask);

  mux4to1 u_mux (
    .D (d),
    .S (r_sel),
    .Y (w_mux_y)
  );

  // State, owner index, priority pointer and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Arbitration: initial grant, hold, release hand-off and timeout rotation
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any.found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick_any.idx;
          w_ptr_nxt   = w_pick_any.idx + 2'd1;
          w_cnt_nxt   = ONE_C;
        end
      end
      GRANT: begin
        if (!req[r_sel] || (r_cnt >= MAX_C)) begin
          // Owner released or used up its slot: hand over to a waiter if any.
          if (w_pick_other.found) begin
            w_sel_nxt = w_pick_other.idx;
            w_ptr_nxt = w_pick_other.idx + 2'd1;
            w_cnt_nxt = ONE_C;
          end else if (!req[r_sel]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            // Sole requester at timeout keeps the mux with a fresh slot.
            w_cnt_nxt = ONE_C;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant outputs decoded from the registered owner; sel holds while idle
  always_comb begin
    gnt  = '0;
    busy = 1'b0;
    if (r_state == GRANT) begin
      gnt  = w_owner_mask;
      busy = 1'b1;
    end
  end

  assign sel = r_sel;

  // Output stage: capture the mux bit for each granted cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_p1   <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= busy;
      if (busy) begin
        r_y_p1 <= w_mux_y;
      end
    end
  end

  assign y       = r_y_p1;
  assign y_valid = r_vld_p1;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: three instances (MAX_HOLD 1, 2, 8)
// share stimulus; directed vectors, corner sequences and random traffic are
// compared against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] gnt_w  [3];
  logic [1:0] sel_w  [3];
  logic       busy_w [3];
  logic       y_w    [3];
  logic       yv_w   [3];

  int n_chk;
  int n_fail;

  // Behavioural model state, one set per instance.
  int   hold_c [3];
  int   own    [3];
  int   mptr   [3];
  int   held   [3];
  int   msel   [3];
  logic my     [3];
  logic myv    [3];
  logic model_on;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       yv;
  } vec_t;

  vec_t tbl [23];

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt_w[0]), .sel(sel_w[0]),
    .busy(busy_w[0]), .y(y_w[0]), .y_valid(yv_w[0]));
  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt_w[1]), .sel(sel_w[1]),
    .busy(busy_w[1]), .y(y_w[1]), .y_valid(yv_w[1]));
  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_h8 (
    .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt_w[2]), .sel(sel_w[2]),
    .busy(busy_w[2]), .y(y_w[2]), .y_valid(yv_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      own[m]  = -1;
      mptr[m] = 0;
      held[m] = 0;
      msel[m] = 0;
      my[m]   = 1'b0;
      myv[m]  = 1'b0;
    end
  endtask

  task automatic model_grant(input int m, input int idx);
    own[m]  = idx;
    msel[m] = idx;
    mptr[m] = (idx + 1) % 4;
    held[m] = 1;
  endtask

  // One clock edge of the arbitration rules, applied to each model.
  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      int pick;
      int cand;
      pick = -1;
      if (own[m] >= 0) begin
        my[m]  = d[own[m]];
        myv[m] = 1'b1;
      end else begin
        myv[m] = 1'b0;
      end
      if (own[m] < 0) begin
        for (int k = 0; k < 4; k++) begin
          cand = (mptr[m] + k) % 4;
          if (pick < 0 && req[cand]) pick = cand;
        end
        if (pick >= 0) model_grant(m, pick);
      end else if (!req[own[m]] || held[m] == hold_c[m]) begin
        for (int k = 0; k < 4; k++) begin
          cand = (mptr[m] + k) % 4;
          if (pick < 0 && req[cand] && cand != own[m]) pick = cand;
        end
        if (pick >= 0) model_grant(m, pick);
        else if (!req[own[m]]) own[m] = -1;
        else held[m] = 1;
      end else begin
        held[m] = held[m] + 1;
      end
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("model gnt h%0d", hold_c[m]), int'(gnt_w[m]),
          own[m] >= 0 ? (1 << own[m]) : 0);
      chk($sformatf("model sel h%0d", hold_c[m]), int'(sel_w[m]), msel[m]);
      chk($sformatf("model busy h%0d", hold_c[m]), int'(busy_w[m]), int'(own[m] >= 0));
      chk($sformatf("model y h%0d", hold_c[m]), int'(y_w[m]), int'(my[m]));
      chk($sformatf("model yv h%0d", hold_c[m]), int'(yv_w[m]), int'(myv[m]));
      chk($sformatf("onehot h%0d", hold_c[m]), int'($countones(gnt_w[m]) <= 1), 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (model_on) model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    hold_c[0] = 1;
    hold_c[1] = 2;
    hold_c[2] = 8;
    model_on = 1'b1;
    req = 4'b0000;
    d   = 4'b0000;
    rst = 1'b0;

    tbl[0]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{4'b0011, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{4'b0011, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{4'b0101, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{4'b0101, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{4'b0101, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{4'b0101, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{4'b0000, 4'b1010, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{4'b0000, 4'b1010, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[21] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};

    // Reset values
    do_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("reset gnt", int'(gnt_w[m]), 0);
      chk("reset sel", int'(sel_w[m]), 0);
      chk("reset busy", int'(busy_w[m]), 0);
      chk("reset y", int'(y_w[m]), 0);
      chk("reset yv", int'(yv_w[m]), 0);
    end

    // Directed vectors on the MAX_HOLD=2 instance
    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      tick();
      chk($sformatf("tbl[%0d] gnt", i), int'(gnt_w[1]), int'(tbl[i].gnt));
      chk($sformatf("tbl[%0d] sel", i), int'(sel_w[1]), int'(tbl[i].sel));
      chk($sformatf("tbl[%0d] busy", i), int'(busy_w[1]), int'(tbl[i].busy));
      chk($sformatf("tbl[%0d] y", i), int'(y_w[1]), int'(tbl[i].y));
      chk($sformatf("tbl[%0d] yv", i), int'(yv_w[1]), int'(tbl[i].yv));
    end

    // Sole requester past the hold limit keeps the grant
    do_reset();
    req = 4'b1000;
    d   = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sole gnt h8", int'(gnt_w[2]), 8);
      chk("sole busy h8", int'(busy_w[2]), 1);
    end

    // MAX_HOLD=1 rotates every cycle under full contention
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rotate gnt h1", int'(gnt_w[0]), 1 << (i % 4));
    end

    // Asynchronous reset between edges, then restart from pointer 0
    do_reset();
    d   = 4'b1111;
    req = 4'b0010;
    tick();
    tick();
    chk("pre-rst gnt", int'(gnt_w[1]), 2);
    chk("pre-rst y", int'(y_w[1]), 1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async gnt", int'(gnt_w[1]), 0);
    chk("async sel", int'(sel_w[1]), 0);
    chk("async busy", int'(busy_w[1]), 0);
    chk("async y", int'(y_w[1]), 0);
    chk("async yv", int'(yv_w[1]), 0);
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post-rst gnt", int'(gnt_w[1]), 2);
    chk("post-rst sel", int'(sel_w[1]), 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) req[b] = ~req[b];
      end
      d = 4'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Shares the 4-to-1 multiplexer datapath (`mux4to1`) between four requesters, each of which owns one mux data input.
- Grants the mux with a round-robin policy and drives the mux select from the grant.
- Bounds each grant to `MAX_HOLD` cycles so no requester can hold the mux indefinitely.
- Registers the mux output with a valid flag, so downstream logic sees one bit per granted cycle from the current owner.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held while another requester is waiting. Legal range 1..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  4: request per requester; held high for as long as the mux is wanted.
- `d`  in  4: data bit per requester, feeding mux inputs `D[3:0]`.
- `gnt`  out  4: one-hot grant, or all-zero.
- `sel`  out  2: mux select, equal to the index of the granted requester.
- `busy`  out  1: high when `gnt` is nonzero.
- `y`  out  1: registered mux output.
- `y_valid`  out  1: `y` holds data from a granted cycle.

## Operation
- Reset values: `gnt`=0000, `sel`=00, `busy`=0, `y`=0, `y_valid`=0.
- Reset values of internal state: priority pointer `ptr`=0, hold counter=0, state IDLE.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Arbitration: pick the first set bit of `req`, searching from `ptr` upward with wrap-around 3→0.
  - Granting index i sets `gnt`=1<<i and `sel`=i.
  - On every grant change, `ptr` becomes (i+1) mod 4.
- IDLE → GRANT: any `req` bit is set at a clock edge. The hold counter is loaded with 1.
- GRANT, with `req[sel]`=1 and counter < MAX_HOLD: keep the grant and increment the counter.
- GRANT, with `req[sel]`=0 (release): re-arbitrate at the same edge, excluding the releasing requester.
  - If another requester is pending, grant it directly with no idle cycle; the counter reloads to 1.
  - Otherwise, go to IDLE.
- GRANT, with counter = MAX_HOLD and `req[sel]`=1 (timeout):
  - If another requester is pending, forcibly rotate to the next requester by round-robin.
  - If no other requester is pending, re-grant the same requester and reload the counter to 1.
- Datapath: every cycle, `y` <= mux(`d`, `sel`) and `y_valid` <= `busy`. When not busy, `y` keeps its last value.
- `sel` holds its last value in IDLE.

## Timing
- `req` rising before edge N → `gnt`/`sel`/`busy` valid after edge N (latency 1 cycle).
- `y`/`y_valid` lag `gnt` by one cycle: `y` after edge N+1 reflects `d[sel]` sampled at edge N+1.
- `req[sel]` dropped before edge N → grant changes or clears after edge N. The cycle after a release still carries `y_valid`=1 for the last granted cycle.
- Simultaneous release plus new requests: one arbitration at that edge, with no idle cycle and no double grant.
- `gnt` is always one-hot or zero, including across hand-offs.
- Asserting `rst` mid-grant clears all outputs and state immediately, without waiting for a clock edge.
- MAX_HOLD=1: under contention the grant rotates every cycle.

## Structure
- Shared package (an `include` header): state encodings IDLE/GRANT, `NUM_REQ`=4, select width 2.
- Sub-modules:
  - Instantiate the existing `mux4to1` combinationally, with `D`=`d`, `S`=`sel`; the output register lives in the arbiter.
  - A round-robin priority-pick function (or a small `rr_pick4` sub-module) returns the chosen index and an any-pending flag, given `req`, `ptr` and an exclude mask.

## Test plan
- Reset, then a single request: `req`=0100 → `gnt`=0100, `sel`=10 after 1 edge. With `d`=0100, the next cycle gives `y`=1, `y_valid`=1. Dropping `req` → `gnt`=0000, and `y_valid`=0 two edges later.
- Round-robin fairness: `req`=1111 held with MAX_HOLD=2 → grant order 0,0,1,1,2,2,3,3,0, with `sel` tracking the grant.
- Release hand-off: grant on 1 with `req`=0011; drop bit 1 → `gnt`=0001 at the next edge, with no zero-grant cycle.
- Timeout with a sole requester: `req`=1000 held for 20 cycles with MAX_HOLD=8 → `gnt`=1000 continuously, counter reloads, and `busy` never drops.
- Pointer wrap: last grant to 3, then `req`=0101 → grant 0 first, then 2.
- Async reset mid-grant: assert `rst` between edges while `gnt`=0010 → `gnt`, `sel`, `busy`, `y`, `y_valid` go to 0 immediately. After release, `req`=0010 is re-granted with `ptr` restarted from 0.
